playback_controller: RTL and testbench

Transport controller for the music player's elapsed-time timer. It turns one-cycle user commands (play/pause, stop, skip forward, skip back) and the system clock into the timer's control signals: clear pulse, count enable and signed step. It also keeps a shadow copy of the playback position so that skips are clamped to the track, and it ends playback at the track length. It sits between the button debouncers and the timer/display datapath.

---
 rtl/playback_controller.sv | 142 ++++++++++++++
 tb/tb_playback_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_controller.sv
// Transport controller for the elapsed-time timer: turns one-cycle user commands
// into timer clear/count/step pulses and keeps a clamped shadow of the position.
module playback_controller #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned SKIP_SECONDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_play_pause_i,
  input  logic       cmd_stop_i,
  input  logic       cmd_fwd_i,
  input  logic       cmd_back_i,
  input  logic [8:0] track_len_i,
  output logic       timer_reset_o,
  output logic       timer_count_o,
  output logic [8:0] timer_adder_o,
  output logic [8:0] position_o,
  output logic [1:0] state_o,
  output logic       song_done_o
);

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    PLAYING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_e;

  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [9:0]    SKIP      = 10'(SKIP_SECONDS);

  state_e        state_q, state_d;
  logic [8:0]    position_q, position_d;
  logic [8:0]    len_q, len_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          timer_reset_q, timer_reset_d;
  logic          timer_count_q, timer_count_d;
  logic [8:0]    timer_adder_q, timer_adder_d;
  logic          song_done_q, song_done_d;

  logic          tick;
  logic [9:0]    base_pos;
  logic [9:0]    target_pos;

  assign tick = (state_q == PLAYING) && (presc_q == PRESC_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= STOPPED;
      position_q    <= '0;
      len_q         <= '0;
      presc_q       <= '0;
      timer_reset_q <= 1'b0;
      timer_count_q <= 1'b0;
      timer_adder_q <= 9'd1;
      song_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      position_q    <= position_d;
      len_q         <= len_d;
      presc_q       <= presc_d;
      timer_reset_q <= timer_reset_d;
      timer_count_q <= timer_count_d;
      timer_adder_q <= timer_adder_d;
      song_done_q   <= song_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    position_d    = position_q;
    len_d         = len_q;
    presc_d       = presc_q;
    timer_reset_d = 1'b0;
    timer_count_d = 1'b0;
    timer_adder_d = 9'd1;
    song_done_d   = 1'b0;
    base_pos      = {1'b0, position_q} + {9'd0, tick};
    target_pos    = base_pos;

    // The prescaler runs on the current state, so a tick sampled together with a pause still counts.
    if (state_q == PLAYING) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (cmd_stop_i) begin
      state_d       = STOPPED;
      position_d    = '0;
      presc_d       = '0;
      timer_reset_d = 1'b1;
    end else begin
      case (state_q)
        STOPPED: begin
          if (cmd_play_pause_i && (track_len_i != 9'd0)) begin
            len_d   = track_len_i;
            presc_d = '0;
            state_d = PLAYING;
          end
        end
        DONE: begin
          if (cmd_play_pause_i) begin
            timer_reset_d = 1'b1;
            position_d    = '0;
            presc_d       = '0;
            len_d         = track_len_i;
            state_d       = PLAYING;
          end
        end
        default: begin
          if (cmd_play_pause_i) begin
            state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
          end else if (cmd_fwd_i) begin
            target_pos = ((base_pos + SKIP) > {1'b0, len_q}) ? {1'b0, len_q} : base_pos + SKIP;
          end else if (cmd_back_i) begin
            target_pos = (base_pos >= SKIP) ? base_pos - SKIP : 10'd0;
          end

          // Tick and skip merge into one step; a fully clamped skip emits nothing.
          if (target_pos != {1'b0, position_q}) begin
            timer_count_d = 1'b1;
            timer_adder_d = target_pos[8:0] - position_q;
            position_d    = target_pos[8:0];
          end

          if (target_pos == {1'b0, len_q}) begin
            state_d     = DONE;
            song_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign timer_reset_o = timer_reset_q;
  assign timer_count_o = timer_count_q;
  assign timer_adder_o = timer_adder_q;
  assign position_o    = position_q;
  assign state_o       = state_q;
  assign song_done_o   = song_done_q;

endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: directed transport scenarios followed by random
// commands, all compared each cycle against a seconds-level model of the player.
module tb_playback_controller;

  localparam int TD = 4;
  localparam int SK = 10;

  localparam int S_STOPPED = 0;
  localparam int S_PLAYING = 1;
  localparam int S_PAUSED  = 2;
  localparam int S_DONE    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmdPlayPause = 1'b0;
  logic       cmdStop = 1'b0;
  logic       cmdFwd = 1'b0;
  logic       cmdBack = 1'b0;
  logic [8:0] trackLen = 9'd0;
  logic       timerReset;
  logic       timerCount;
  logic [8:0] timerAdder;
  logic [8:0] position;
  logic [1:0] state;
  logic       songDone;

  int errors = 0;
  int checks = 0;

  // Model: player state, seconds played, latched length, and playing cycles since start.
  int         mState, mPos, mLen, mElapsed;
  logic       eReset, eCount, eDone;
  logic [8:0] eAdder;
  logic [8:0] curLen;

  always #5 clk = ~clk;

  playback_controller #(.TICK_DIV(TD), .SKIP_SECONDS(SK)) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_play_pause_i (cmdPlayPause),
    .cmd_stop_i       (cmdStop),
    .cmd_fwd_i        (cmdFwd),
    .cmd_back_i       (cmdBack),
    .track_len_i      (trackLen),
    .timer_reset_o    (timerReset),
    .timer_count_o    (timerCount),
    .timer_adder_o    (timerAdder),
    .position_o       (position),
    .state_o          (state),
    .song_done_o      (songDone)
  );

  function automatic bit willTick();
    return (mState == S_PLAYING) && ((mElapsed % TD) == TD - 1);
  endfunction

  task automatic modelReset();
    mState = S_STOPPED; mPos = 0; mLen = 0; mElapsed = 0;
    eReset = 1'b0; eCount = 1'b0; eAdder = 9'd1; eDone = 1'b0;
  endtask

  task automatic modelStep(input bit pp, input bit st, input bit fw, input bit bk, input int tl);
    bit tick;
    int t;
    tick = willTick();
    eReset = 1'b0; eCount = 1'b0; eAdder = 9'd1; eDone = 1'b0;
    if (mState == S_PLAYING) mElapsed++;
    if (st) begin
      eReset = 1'b1; mPos = 0; mElapsed = 0; mState = S_STOPPED;
    end else if (mState == S_STOPPED) begin
      if (pp && tl != 0) begin
        mLen = tl; mElapsed = 0; mState = S_PLAYING;
      end
    end else if (mState == S_DONE) begin
      if (pp) begin
        eReset = 1'b1; mPos = 0; mElapsed = 0; mLen = tl; mState = S_PLAYING;
      end
    end else begin
      t = mPos + (tick ? 1 : 0);
      if (pp) mState = (mState == S_PLAYING) ? S_PAUSED : S_PLAYING;
      else if (fw) t = (t + SK > mLen) ? mLen : t + SK;
      else if (bk) t = (t - SK < 0) ? 0 : t - SK;
      if (t != mPos) begin
        eCount = 1'b1;
        eAdder = 9'(t - mPos);
        mPos = t;
      end
      if (t == mLen) begin
        mState = S_DONE;
        eDone = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [22:0] obs, exp;
    obs = {state, position, timerCount, timerAdder, timerReset, songDone};
    exp = {2'(mState), 9'(mPos), eCount, eAdder, eReset, eDone};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed st=%0d pos=%0d cnt=%b add=%h rst=%b done=%b, expected st=%0d pos=%0d cnt=%b add=%h rst=%b done=%b",
             tag, state, position, timerCount, timerAdder, timerReset, songDone,
             mState, mPos, eCount, eAdder, eReset, eDone);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBound(input string tag, input bit ok);
    checks++;
    assert (ok) else begin
      errors++;
      $error("[TB] FAIL %s: wait bound expired, observed timeout expected condition", tag);
    end
  endtask

  task automatic applyStimulus(input bit pp, input bit st, input bit fw, input bit bk, input string tag);
    @(negedge clk);
    cmdPlayPause = pp; cmdStop = st; cmdFwd = fw; cmdBack = bk; trackLen = curLen;
    modelStep(pp, st, fw, bk, int'(curLen));
    @(posedge clk);
    #1;
    cmdPlayPause = 1'b0; cmdStop = 1'b0; cmdFwd = 1'b0; cmdBack = 1'b0;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int n;
    int r;
    $display("[TB] playback_controller bench, TICK_DIV=%0d SKIP=%0d", TD, SK);
    modelReset();
    curLen = 9'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkOutput("reset state");
    @(negedge clk) reset = 1'b0;
    idle("after reset");

    // Zero-length track is refused
    curLen = 9'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "play len0");
    checkValue("len0 stays stopped", 32'(state), 32'd0);

    // Basic play: first tick TICK_DIV cycles after the accepting edge
    curLen = 9'd20;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start");
    for (int i = 0; i < TD; i++) idle("basic play");
    checkValue("first tick count", 32'(timerCount), 32'd1);
    checkValue("first tick pos", 32'(position), 32'd1);
    for (int i = 0; i < 3 * TD; i++) idle("basic play");
    checkValue("basic pos 4", 32'(position), 32'd4);

    // Pause at presc=2, hold 50 cycles, resume
    n = 0;
    while (!(mState == S_PLAYING && (mElapsed % TD) == 2) && n < 20) begin idle("to presc2"); n++; end
    checkBound("reach presc2", n < 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "pause");
    for (int i = 0; i < 50; i++) idle("paused hold");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "resume");
    idle("tick after resume");
    checkValue("resume tick", 32'(timerCount), 32'd1);

    // Forward clamp at end of track
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "stop");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start len20");
    n = 0;
    while (!(mPos == 5 && !willTick()) && n < 100) begin idle("to pos5"); n++; end
    checkBound("reach pos5", n < 100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "fwd to 15");
    n = 0;
    while (willTick() && n < 10) begin idle("avoid tick"); n++; end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "fwd clamp");
    checkValue("clamp adder", 32'(timerAdder), 32'd5);
    checkValue("clamp pos", 32'(position), 32'd20);
    checkValue("clamp done", 32'(songDone), 32'd1);
    checkValue("clamp state", 32'(state), 32'd3);
    for (int i = 0; i < 10; i++) idle("done quiet");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "fwd in done");

    // Restart from DONE relatches a longer track
    curLen = 9'd30;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "restart");
    checkValue("restart timer_reset", 32'(timerReset), 32'd1);
    checkValue("restart pos", 32'(position), 32'd0);
    checkValue("restart state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (willTick() && n < 10) begin idle("avoid tick"); n++; end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "fwd relatched");
    end
    checkValue("relatched len reached", 32'(position), 32'd30);

    // Back clamp to zero
    curLen = 9'd20;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "stop");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start");
    n = 0;
    while (!(mPos == 3 && !willTick()) && n < 100) begin idle("to pos3"); n++; end
    checkBound("reach pos3", n < 100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "back clamp");
    checkValue("back adder", 32'(timerAdder), 32'h1FD);
    checkValue("back pos", 32'(position), 32'd0);

    // Tick and skip merged
    n = 0;
    while (!(mPos == 4 && willTick()) && n < 100) begin idle("to pos4 tick"); n++; end
    checkBound("reach pos4 tick", n < 100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "merge");
    checkValue("merge adder", 32'(timerAdder), 32'd11);
    checkValue("merge pos", 32'(position), 32'd15);

    // Priority: stop beats play_pause and fwd
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "priority");
    checkValue("prio reset", 32'(timerReset), 32'd1);
    checkValue("prio count", 32'(timerCount), 32'd0);
    checkValue("prio state", 32'(state), 32'd0);

    // Asynchronous reset mid-playback
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "start");
    for (int i = 0; i < 6; i++) idle("pre reset");
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutput("async reset");
    @(negedge clk) reset = 1'b0;
    idle("after async reset");

    // Random commands against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 49) == 0) curLen = 9'($urandom_range(1, 40));
      if (r < 2)       applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, "rand stop");
      else if (r < 8)  applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand play");
      else if (r < 14) applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), "rand fwd");
      else if (r < 20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "rand back");
      else             idle("rand idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
